// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed 7-segment scan: rebuilds num1..num4 from enable/segment.
// Optional watchdog/stale detection is compiled in with `define SEG7_TIMEOUT_EN.
module seg7_scan_decoder #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] enable,
  input  logic [6:0] segment,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic       frame_valid,
  output logic       pattern_err,
  output logic       stale
);

  localparam int CW = $clog2(SETTLE + 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  if (SETTLE < 1 || TIMEOUT < 2) begin : g_param_check
    $error("seg7_scan_decoder: SETTLE must be >= 1 and TIMEOUT >= 2");
  end

  // Returns {legal, nibble}; the argument is the raw active-low segment bus.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg_n);
    logic [6:0] lit;
    lit = ~seg_n;
    case (lit)
      7'h3F:   glyph_decode = {1'b1, 4'h0};
      7'h06:   glyph_decode = {1'b1, 4'h1};
      7'h5B:   glyph_decode = {1'b1, 4'h2};
      7'h4F:   glyph_decode = {1'b1, 4'h3};
      7'h66:   glyph_decode = {1'b1, 4'h4};
      7'h6D:   glyph_decode = {1'b1, 4'h5};
      7'h7D:   glyph_decode = {1'b1, 4'h6};
      7'h07:   glyph_decode = {1'b1, 4'h7};
      7'h7F:   glyph_decode = {1'b1, 4'h8};
      7'h6F:   glyph_decode = {1'b1, 4'h9};
      7'h77:   glyph_decode = {1'b1, 4'hA};
      7'h7C:   glyph_decode = {1'b1, 4'hB};
      7'h39:   glyph_decode = {1'b1, 4'hC};
      7'h5E:   glyph_decode = {1'b1, 4'hD};
      7'h79:   glyph_decode = {1'b1, 4'hE};
      7'h71:   glyph_decode = {1'b1, 4'hF};
      default: glyph_decode = 5'b0_0000;
    endcase
  endfunction

  // Returns {valid, index}; blanking and ghosting (zero or several lows) are invalid.
  function automatic logic [2:0] pos_decode(input logic [7:0] en_n);
    if (en_n[7:4] != 4'hF) begin
      pos_decode = 3'b000;
    end else begin
      case (en_n[3:0])
        4'b1110: pos_decode = 3'b100;
        4'b1101: pos_decode = 3'b101;
        4'b1011: pos_decode = 3'b110;
        4'b0111: pos_decode = 3'b111;
        default: pos_decode = 3'b000;
      endcase
    end
  endfunction

  logic [7:0]    en_q, en_d;
  logic [6:0]    seg_q, seg_d;
  state_t        state_r, state_nx;
  logic [CW-1:0] cnt_r, cnt_nx, cnt_inc_s;
  logic [3:0]    shadow_r [4];
  logic [3:0]    mask_r, mask_nx;
  logic          changed_s, capture_s, cap_ok_s, frame_load_s, drop_s;
  logic [2:0]    pos_s;
  logic [4:0]    glyph_s;

  assign changed_s    = (en_q != en_d) || (seg_q != seg_d);
  assign pos_s        = pos_decode(en_q);
  assign glyph_s      = glyph_decode(seg_q);
  assign cnt_inc_s    = cnt_r + CW'(1);
  assign cap_ok_s     = capture_s && glyph_s[4];
  assign frame_load_s = (mask_r == 4'hF);

  // Dwell tracker: one capture per stable enable/segment interval.
  always_comb begin
    state_nx  = state_r;
    cnt_nx    = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pos_s[2]) begin
          state_nx = ST_SETTLE;
          cnt_nx   = CW'(1);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (changed_s) begin
          state_nx = pos_s[2] ? ST_SETTLE : ST_IDLE;
          cnt_nx   = CW'(1);
        end else if (cnt_inc_s >= CW'(SETTLE)) begin
          capture_s = 1'b1;
          state_nx  = ST_HOLD;
        end else begin
          cnt_nx = cnt_inc_s;
        end
      end
      ST_HOLD: begin
        if (changed_s) begin
          state_nx = pos_s[2] ? ST_SETTLE : ST_IDLE;
          cnt_nx   = CW'(1);
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // A capture landing on the frame-completion cycle goes into the freshly cleared mask.
  always_comb begin
    mask_nx = (frame_load_s || drop_s) ? 4'h0 : mask_r;
    mask_nx = mask_nx | (cap_ok_s ? (4'b0001 << pos_s[1:0]) : 4'b0000);
  end

  // Input stage, FSM state and frame assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 8'hFF;
      seg_q       <= 7'h7F;
      en_d        <= 8'hFF;
      seg_d       <= 7'h7F;
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      mask_r      <= 4'h0;
      num1        <= 4'h0;
      num2        <= 4'h0;
      num3        <= 4'h0;
      num4        <= 4'h0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      for (int i = 0; i < 4; i++) shadow_r[i] <= 4'h0;
    end else begin
      en_q        <= enable;
      seg_q       <= segment;
      en_d        <= en_q;
      seg_d       <= seg_q;
      state_r     <= state_nx;
      cnt_r       <= cnt_nx;
      mask_r      <= mask_nx;
      frame_valid <= frame_load_s;
      pattern_err <= capture_s && !glyph_s[4];
      if (frame_load_s) begin
        num1 <= shadow_r[0];
        num2 <= shadow_r[1];
        num3 <= shadow_r[2];
        num4 <= shadow_r[3];
      end
      if (cap_ok_s) shadow_r[pos_s[1:0]] <= glyph_s[3:0];
    end
  end

`ifdef SEG7_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_r;

  assign drop_s = !frame_load_s && (wd_r == WW'(TIMEOUT - 1));

  // Watchdog: saturating count since the last frame; drops the partial frame on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_r  <= '0;
      stale <= 1'b0;
    end else if (frame_load_s) begin
      wd_r  <= '0;
      stale <= 1'b0;
    end else begin
      if (wd_r != WW'(TIMEOUT)) wd_r <= wd_r + WW'(1);
      if (drop_s) stale <= 1'b1;
    end
  end
`else
  assign drop_s = 1'b0;

  // Without the watchdog the stale flag never rises.
  always_ff @(posedge clk) begin
    stale <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a bench-side model predicts frames and glyph errors.
module tb_seg7_scan_decoder;

  localparam int SETTLE = 2;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S7 = 7'h78, S8 = 7'h00, SF = 7'h0E, SBAD = 7'h7E, SOFF = 7'h7F;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] enable;
  logic [6:0] segment;
  logic [3:0] num1, num2, num3, num4;
  logic       frame_valid, pattern_err, stale;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .segment(segment),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .frame_valid(frame_valid), .pattern_err(pattern_err), .stale(stale)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;
  int n_err    = 0;
  int exp_err  = 0;

  logic [15:0] exp_q [$];
  logic [15:0] exp_word;
  logic [6:0]  hi_tbl [16];
  logic [3:0]  m_shadow [4];
  logic [3:0]  m_mask;
  logic [7:0]  prev_en;
  logic [6:0]  prev_seg;
  int          run;
  bit          run_capt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold one enable/segment pair for n cycles and update the model when it should capture.
  task automatic drive(input logic [7:0] en, input logic [6:0] sg, input int n);
    logic [3:0] lo;
    int idx;
    int val;
    enable  = en;
    segment = sg;
    if (en == prev_en && sg == prev_seg) begin
      run += n;
    end else begin
      run      = n;
      run_capt = 1'b0;
    end
    prev_en  = en;
    prev_seg = sg;
    lo = ~en[3:0];
    if (!run_capt && run >= SETTLE && en[7:4] == 4'hF && $countones(lo) == 1) begin
      run_capt = 1'b1;
      idx = 0;
      for (int i = 0; i < 4; i++) if (lo[i]) idx = i;
      val = -1;
      for (int g = 0; g < 16; g++) if (hi_tbl[g] == ~sg) val = g;
      if (val < 0) begin
        exp_err++;
      end else begin
        m_shadow[idx] = val[3:0];
        m_mask[idx]   = 1'b1;
        if (m_mask == 4'hF) begin
          exp_q.push_back({m_shadow[0], m_shadow[1], m_shadow[2], m_shadow[3]});
          m_mask = 4'h0;
        end
      end
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    enable   = 8'hFF;
    segment  = SOFF;
    @(negedge clk);
    rst      = 1'b0;
    m_mask   = 4'h0;
    prev_en  = 8'hFF;
    prev_seg = SOFF;
    run      = 0;
    run_capt = 1'b1;
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      n_frames++;
      check_eq("frame_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check_eq("frame_digits", {16'h0, num1, num2, num3, num4}, {16'h0, exp_word});
      end
    end
    if (!rst && pattern_err) n_err++;
  end

  initial begin
    hi_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
    rst = 1'b1;
    enable = 8'hFF;
    segment = SOFF;
    repeat (2) @(negedge clk);
    do_reset();

    check_eq("reset_nums", {16'h0, num1, num2, num3, num4}, 32'h0);
    check_eq("reset_frame_valid", 32'(frame_valid), 32'd0);
    check_eq("reset_pattern_err", 32'(pattern_err), 32'd0);
    check_eq("reset_stale", 32'(stale), 32'd0);

    // Single-cycle dwells never settle.
    for (int p = 0; p < 4; p++) begin
      drive(8'hFE, S7, 1); drive(8'hFD, S3, 1); drive(8'hFB, SF, 1); drive(8'hF7, S0, 1);
    end
    drive(8'hFF, SOFF, 4);
    check_eq("short_dwell_frames", n_frames, 0);
    check_eq("short_dwell_nums", {16'h0, num1, num2, num3, num4}, 32'h0);

    // Round robin, three passes: one frame per pass.
    for (int p = 0; p < 3; p++) begin
      drive(8'hFE, S7, 3); drive(8'hFD, S3, 3); drive(8'hFB, SF, 3); drive(8'hF7, S0, 3);
    end
    drive(8'hFF, SOFF, 6);
    check_eq("round_robin_frames", n_frames, 3);
    check_eq("round_robin_nums", {16'h0, num1, num2, num3, num4}, 32'h73F0);

    // Ghost (two enables low) and blanking intervals between digits.
    drive(8'hFE, S1, 3); drive(8'hF6, S8, 3); drive(8'hFF, SOFF, 3);
    drive(8'hFD, S2, 3); drive(8'hF6, S8, 3); drive(8'hFF, SOFF, 3);
    drive(8'hFB, S8, 3); drive(8'hF6, S8, 3); drive(8'hFF, SOFF, 3);
    drive(8'hF7, S7, 3); drive(8'hFF, SOFF, 6);
    check_eq("ghost_frames", n_frames, 4);
    check_eq("ghost_nums", {16'h0, num1, num2, num3, num4}, 32'h1287);

    // Illegal glyph on digit 2, then a legal 3 completes the frame.
    drive(8'hFE, S3, 3); drive(8'hFD, SBAD, 3); drive(8'hFF, SOFF, 3);
    check_eq("bad_glyph_err_pulses", n_err, 1);
    check_eq("bad_glyph_num2_kept", 32'(num2), 32'h2);
    drive(8'hFB, S0, 3); drive(8'hF7, S1, 3); drive(8'hFF, SOFF, 6);
    check_eq("bad_glyph_no_frame_yet", n_frames, 4);
    drive(8'hFD, S3, 3); drive(8'hFF, SOFF, 6);
    check_eq("bad_glyph_frames", n_frames, 5);
    check_eq("bad_glyph_nums", {16'h0, num1, num2, num3, num4}, 32'h3301);
    check_eq("pattern_err_count", n_err, exp_err);

    // Reset mid-frame discards partial captures.
    drive(8'hFE, S8, 3); drive(8'hFD, S2, 3);
    do_reset();
    check_eq("midreset_nums", {16'h0, num1, num2, num3, num4}, 32'h0);
    check_eq("midreset_frame_valid", 32'(frame_valid), 32'd0);
    drive(8'hFB, S1, 3); drive(8'hF7, S7, 3); drive(8'hFE, S0, 3); drive(8'hFF, SOFF, 6);
    check_eq("midreset_three_digits", n_frames, 5);
    drive(8'hFD, S3, 3); drive(8'hFF, SOFF, 6);
    check_eq("midreset_frames", n_frames, 6);
    check_eq("midreset_final_nums", {16'h0, num1, num2, num3, num4}, 32'h0317);

`ifdef SEG7_TIMEOUT_EN
    check_eq("stale_before_idle", 32'(stale), 32'd0);
    drive(8'hFF, SOFF, 70);
    check_eq("stale_after_idle", 32'(stale), 32'd1);
    check_eq("stale_nums_held", {16'h0, num1, num2, num3, num4}, 32'h0317);
    drive(8'hFE, S7, 3); drive(8'hFD, S3, 3); drive(8'hFB, SF, 3); drive(8'hF7, S0, 3);
    drive(8'hFF, SOFF, 6);
    check_eq("stale_cleared", 32'(stale), 32'd0);
    check_eq("stale_recovery_frames", n_frames, 7);
`else
    drive(8'hFF, SOFF, 70);
    check_eq("stale_tied_low", 32'(stale), 32'd0);
    check_eq("idle_no_frames", n_frames, 6);
`endif

    check_eq("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
